regfile_dual_read: RTL and testbench

//   32-entry x 32-bit general-purpose register file for the single-cycle core.

---
 rtl/regfile_dual_read.sv | 61 ++++++
 tb/tb_regfile_dual_read.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_dual_read.sv
// 32 x 32 register file: one synchronous write port, two combinational read ports.
// Entry 0 is hardwired to zero; optional same-cycle write forwarding on each read port.
module regfile_dual_read #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter bit BYPASS = 1'b0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] writeEn;
    logic             bypassA;
    logic             bypassB;
    logic [WIDTH-1:0] storedA;
    logic [WIDTH-1:0] storedB;

    // One-hot write decode; bit 0 is never enabled so entry 0 cannot be written.
    always_comb begin
        writeEn = '0;
        for (int i = 1; i < DEPTH; i++) begin
            writeEn[i] = we_i && (waddr_i == AW'(i));
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (writeEn[i]) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        storedA = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
        storedB = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
    end

    // Forwarding is suppressed while clr is high so reads stay zero during reset.
    assign bypassA = BYPASS && !clr_i && writeEn[raddr_a_i];
    assign bypassB = BYPASS && !clr_i && writeEn[raddr_b_i];

    assign rdata_a_o = bypassA ? wdata_i : storedA;
    assign rdata_b_o = bypassB ? wdata_i : storedB;

endmodule

// File: tb/tb_regfile_dual_read.sv
// Directed self-checking bench for regfile_dual_read; one instance without and one with write forwarding.
module tb_regfile_dual_read;

    logic        clk = 1'b0;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddrA;
    logic [4:0]  raddrB;
    logic [31:0] rdataA;
    logic [31:0] rdataB;
    logic [31:0] bypRdataA;
    logic [31:0] bypRdataB;

    int checkCount = 0;
    int failCount  = 0;

    regfile_dual_read #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b0)) dut (
        .clk_i     (clk),
        .clr_i     (clr),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (raddrA),
        .raddr_b_i (raddrB),
        .rdata_a_o (rdataA),
        .rdata_b_o (rdataB)
    );

    regfile_dual_read #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b1)) dutByp (
        .clk_i     (clk),
        .clr_i     (clr),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (raddrA),
        .raddr_b_i (raddrB),
        .rdata_a_o (bypRdataA),
        .rdata_b_o (bypRdataB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One write cycle: drive on the falling edge, release we just after the rising edge.
    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        we    = 1'b1;
        waddr = addr;
        wdata = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic setReads(input logic [4:0] a, input logic [4:0] b);
        raddrA = a;
        raddrB = b;
        #1;
    endtask

    initial begin
        logic [31:0] pattern;
        clr    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddrA = 5'd5;
        raddrB = 5'd31;
        #2;
        checkOutput("resetHeldA", rdataA, 32'h0);
        checkOutput("resetHeldB", rdataB, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // Everything reads zero after reset on both ports
        for (int i = 0; i < 32; i++) begin
            setReads(5'(i), 5'(31 - i));
            checkOutput($sformatf("postResetA[%0d]", i), rdataA, 32'h0);
            checkOutput($sformatf("postResetB[%0d]", 31 - i), rdataB, 32'h0);
        end

        applyStimulus(5'd5, 32'hDEADBEEF);
        setReads(5'd5, 5'd5);
        checkOutput("wr5A", rdataA, 32'hDEADBEEF);
        checkOutput("wr5B", rdataB, 32'hDEADBEEF);
        setReads(5'd4, 5'd6);
        checkOutput("neighbour4", rdataA, 32'h0);
        checkOutput("neighbour6", rdataB, 32'h0);

        applyStimulus(5'd0, 32'hFFFFFFFF);
        setReads(5'd0, 5'd0);
        checkOutput("zeroEntryA", rdataA, 32'h0);
        checkOutput("zeroEntryB", rdataB, 32'h0);
        checkOutput("zeroEntryBypA", bypRdataA, 32'h0);

        for (int i = 1; i < 32; i++) begin
            pattern = 32'(i) * 32'h01010101;
            applyStimulus(5'(i), pattern);
        end
        for (int i = 0; i < 32; i++) begin
            setReads(5'(i), 5'(31 - i));
            pattern = 32'(i) * 32'h01010101;
            checkOutput($sformatf("sweepA[%0d]", i), rdataA, pattern);
            pattern = 32'(31 - i) * 32'h01010101;
            checkOutput($sformatf("sweepB[%0d]", 31 - i), rdataB, pattern);
        end

        // Read-during-write on entry 7
        applyStimulus(5'd7, 32'h11111111);
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'h22222222;
        raddrA = 5'd7;
        raddrB = 5'd8;
        #1;
        checkOutput("rdwNoBypBefore", rdataA, 32'h11111111);
        checkOutput("rdwBypBefore", bypRdataA, 32'h22222222);
        checkOutput("rdwBypOtherPort", bypRdataB, 32'h08080808);
        @(posedge clk);
        #1;
        we = 1'b0;
        checkOutput("rdwNoBypAfter", rdataA, 32'h22222222);
        checkOutput("rdwBypAfter", bypRdataA, 32'h22222222);

        // A forwarded write to address 0 must still read zero
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFFFFFF;
        raddrA = 5'd0;
        #1;
        checkOutput("bypZeroAddr", bypRdataA, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;

        // Asynchronous clear mid-cycle, then a write colliding with clr
        applyStimulus(5'd9, 32'hA5A5A5A5);
        setReads(5'd9, 5'd10);
        checkOutput("entry9Loaded", rdataA, 32'hA5A5A5A5);
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("asyncClrA", rdataA, 32'h0);
        checkOutput("asyncClrB", rdataB, 32'h0);
        checkOutput("asyncClrBypA", bypRdataA, 32'h0);
        we     = 1'b1;
        waddr  = 5'd9;
        wdata  = 32'h12345678;
        raddrB = 5'd9;
        #1;
        checkOutput("clrBlocksBypass", bypRdataB, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("clrDominatesWe", rdataA, 32'h0);
        @(negedge clk);
        we  = 1'b0;
        clr = 1'b0;
        #1;
        checkOutput("afterClrA", rdataA, 32'h0);
        checkOutput("afterClrBypB", bypRdataB, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("noReplay", rdataA, 32'h0);
        setReads(5'd31, 5'd7);
        checkOutput("clr31", rdataA, 32'h0);
        checkOutput("clr7", rdataB, 32'h0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
